// File: rtl/mem_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_req_arbiter_pkg
// Brief  : Shared state encodings, requester IDs and UART addresses for the
//          memory request arbiter.
// Rev    : 1.0
// ============================================================================
package mem_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IC = 2'd1,
    ST_BUSY_LD = 2'd2,
    ST_BUSY_ST = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_LSB = 1'b0,
    REQ_IC  = 1'b1
  } req_id_e;

  localparam logic [31:0] DEF_IO_ADDR0 = 32'h0003_0000;
  localparam logic [31:0] DEF_IO_ADDR1 = 32'h0003_0004;

endpackage
`default_nettype wire

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_req_arbiter
// Brief  : Arbitrates ICache fetches and LSB loads/stores onto a single
//          memory-controller port, one transaction in flight at a time.
// Rev    : 1.0
// ============================================================================
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    BLOCK_WIDTH = 1,
  parameter logic [ADDR_WIDTH-1:0] IO_ADDR0    = ADDR_WIDTH'(DEF_IO_ADDR0),
  parameter logic [ADDR_WIDTH-1:0] IO_ADDR1    = ADDR_WIDTH'(DEF_IO_ADDR1)
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               rdy_in,
  input  logic                               io_buffer_full,
  input  logic                               clear_in,
  input  logic                               ic_req_en,
  input  logic [ADDR_WIDTH-1:0]              ic_req_addr,
  output logic                               ic_rsp_en,
  output logic [(32 << BLOCK_WIDTH)-1:0]     ic_rsp_block,
  input  logic                               lsb_req_en,
  input  logic                               lsb_req_wr,
  input  logic [2:0]                         lsb_req_width,
  input  logic [ADDR_WIDTH-1:0]              lsb_req_addr,
  input  logic [31:0]                        lsb_req_data,
  output logic                               lsb_rsp_r_en,
  output logic                               lsb_rsp_w_en,
  output logic [31:0]                        lsb_rsp_data,
  output logic                               arb2mc_en,
  output logic                               arb2mc_wr,
  output logic [2:0]                         arb2mc_width,
  output logic [ADDR_WIDTH-1:0]              arb2mc_addr,
  output logic [31:0]                        arb2mc_data,
  output logic                               arb2mc_blk,
  input  logic                               mc2arb_done,
  input  logic [(32 << BLOCK_WIDTH)-1:0]     mc2arb_data
);

  localparam int BLK_BITS = 32 << BLOCK_WIDTH;

  arb_state_e              state_q,        state_d;
  req_id_e                 last_grant_q,   last_grant_d;
  logic                    squash_q,       squash_d;
  logic                    ic_rsp_en_q,    ic_rsp_en_d;
  logic [BLK_BITS-1:0]     ic_rsp_block_q, ic_rsp_block_d;
  logic                    lsb_rsp_r_en_q, lsb_rsp_r_en_d;
  logic                    lsb_rsp_w_en_q, lsb_rsp_w_en_d;
  logic [31:0]             lsb_rsp_data_q, lsb_rsp_data_d;
  logic                    mc_en_q,        mc_en_d;
  logic                    mc_wr_q,        mc_wr_d;
  logic [2:0]              mc_width_q,     mc_width_d;
  logic [ADDR_WIDTH-1:0]   mc_addr_q,      mc_addr_d;
  logic [31:0]             mc_data_q,      mc_data_d;
  logic                    mc_blk_q,       mc_blk_d;

  logic w_ic_elig;
  logic w_lsb_elig;
  logic w_io_stall;
  logic w_grant_ic;
  logic w_squash_hit;

  // A requester whose response pulse is still visible has not yet dropped its
  // level request, so it must not be re-granted in that cycle.
  assign w_ic_elig    = ic_req_en && !ic_rsp_en_q && !clear_in;
  assign w_io_stall   = lsb_req_wr && io_buffer_full &&
                        ((lsb_req_addr == IO_ADDR0) || (lsb_req_addr == IO_ADDR1));
  assign w_lsb_elig   = lsb_req_en && !lsb_rsp_r_en_q && !lsb_rsp_w_en_q &&
                        !w_io_stall && (lsb_req_wr || !clear_in);
  assign w_grant_ic   = w_ic_elig && (!w_lsb_elig || (last_grant_q == REQ_LSB));
  assign w_squash_hit = squash_q || clear_in;

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    squash_d       = squash_q;
    ic_rsp_en_d    = 1'b0;
    ic_rsp_block_d = ic_rsp_block_q;
    lsb_rsp_r_en_d = 1'b0;
    lsb_rsp_w_en_d = 1'b0;
    lsb_rsp_data_d = lsb_rsp_data_q;
    mc_en_d        = mc_en_q;
    mc_wr_d        = mc_wr_q;
    mc_width_d     = mc_width_q;
    mc_addr_d      = mc_addr_q;
    mc_data_d      = mc_data_q;
    mc_blk_d       = mc_blk_q;

    case (state_q)
      ST_IDLE: begin
        if (w_ic_elig || w_lsb_elig) begin
          mc_en_d = 1'b1;
          if (w_grant_ic) begin
            last_grant_d = REQ_IC;
            mc_wr_d      = 1'b0;
            mc_width_d   = 3'd0;
            mc_addr_d    = ic_req_addr;
            mc_data_d    = 32'd0;
            mc_blk_d     = 1'b1;
            state_d      = ST_BUSY_IC;
          end else begin
            last_grant_d = REQ_LSB;
            mc_wr_d      = lsb_req_wr;
            mc_width_d   = lsb_req_width;
            mc_addr_d    = lsb_req_addr;
            mc_data_d    = lsb_req_data;
            mc_blk_d     = 1'b0;
            state_d      = lsb_req_wr ? ST_BUSY_ST : ST_BUSY_LD;
          end
        end
      end

      // Speculative reads complete on the bus regardless of a flush; only
      // the reply is suppressed.
      ST_BUSY_IC, ST_BUSY_LD: begin
        squash_d = w_squash_hit;
        if (mc2arb_done) begin
          state_d  = ST_IDLE;
          mc_en_d  = 1'b0;
          squash_d = 1'b0;
          if (!w_squash_hit) begin
            if (state_q == ST_BUSY_IC) begin
              ic_rsp_en_d    = 1'b1;
              ic_rsp_block_d = mc2arb_data;
            end else begin
              lsb_rsp_r_en_d = 1'b1;
              lsb_rsp_data_d = mc2arb_data[31:0];
            end
          end
        end
      end

      ST_BUSY_ST: begin
        if (mc2arb_done) begin
          state_d        = ST_IDLE;
          mc_en_d        = 1'b0;
          lsb_rsp_w_en_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= REQ_LSB;
      squash_q       <= 1'b0;
      ic_rsp_en_q    <= 1'b0;
      ic_rsp_block_q <= '0;
      lsb_rsp_r_en_q <= 1'b0;
      lsb_rsp_w_en_q <= 1'b0;
      lsb_rsp_data_q <= '0;
      mc_en_q        <= 1'b0;
      mc_wr_q        <= 1'b0;
      mc_width_q     <= '0;
      mc_addr_q      <= '0;
      mc_data_q      <= '0;
      mc_blk_q       <= 1'b0;
    end else if (rdy_in) begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      squash_q       <= squash_d;
      ic_rsp_en_q    <= ic_rsp_en_d;
      ic_rsp_block_q <= ic_rsp_block_d;
      lsb_rsp_r_en_q <= lsb_rsp_r_en_d;
      lsb_rsp_w_en_q <= lsb_rsp_w_en_d;
      lsb_rsp_data_q <= lsb_rsp_data_d;
      mc_en_q        <= mc_en_d;
      mc_wr_q        <= mc_wr_d;
      mc_width_q     <= mc_width_d;
      mc_addr_q      <= mc_addr_d;
      mc_data_q      <= mc_data_d;
      mc_blk_q       <= mc_blk_d;
    end
  end

  assign ic_rsp_en    = ic_rsp_en_q;
  assign ic_rsp_block = ic_rsp_block_q;
  assign lsb_rsp_r_en = lsb_rsp_r_en_q;
  assign lsb_rsp_w_en = lsb_rsp_w_en_q;
  assign lsb_rsp_data = lsb_rsp_data_q;
  assign arb2mc_en    = mc_en_q;
  assign arb2mc_wr    = mc_wr_q;
  assign arb2mc_width = mc_width_q;
  assign arb2mc_addr  = mc_addr_q;
  assign arb2mc_data  = mc_data_q;
  assign arb2mc_blk   = mc_blk_q;

endmodule
`default_nettype wire
